// File: rtl/child_sched_pkg.sv
// Shared types and constants for the child slot scheduler.
// Also used by other root-level arbiters built on rr_pick.
package child_sched_pkg;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } sched_state_e;

    localparam int ID_W = 3;
    localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/child_slot_scheduler_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import child_sched_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  rot;
    logic [ID_W:0] raw_d;
    logic [ID_W:0] wrap_d;

    // Rotate so that bit 0 of rot is the requester at ptr.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        valid = 1'b0;
        raw_d = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k[IW-1:0]]) begin
                valid = 1'b1;
                raw_d = {1'b0, ptr} + (ID_W + 1)'(k);
            end
        end
        wrap_d = raw_d;
        if (raw_d >= (ID_W + 1)'(N)) begin
            wrap_d = raw_d - (ID_W + 1)'(N);
        end
    end

    assign idx = wrap_d[ID_W-1:0];

endmodule

// File: rtl/child_slot_scheduler.sv
// Round-robin owner of one exclusive slot shared by the child instances,
// with a per-grant watchdog that reclaims the slot from a stuck owner.
module child_slot_scheduler
    import child_sched_pkg::*;
#(
    parameter int N_CHILD = 5,
    parameter int TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CHILD-1:0] req,
    input  logic [N_CHILD-1:0] done,
    output logic [N_CHILD-1:0] grant,
    output logic               busy,
    output logic [ID_W-1:0]    owner_id,
    output logic               timeout_err,
    output logic [7:0]         err_count
);

    sched_state_e       state_q, state_d;
    logic [N_CHILD-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic               terr_q, terr_d;
    logic [7:0]         errc_q, errc_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               own_done;
    logic               hold_expired;
    logic [ID_W-1:0]    ptr_next;

    rr_pick #(
        .N(N_CHILD)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // grant_q is one-hot on the owner while held, so this masks foreign done bits.
    assign own_done     = |(done & grant_q);
    assign hold_expired = (hcnt_q == 8'(TIMEOUT - 1));
    assign ptr_next     = (owner_q == ID_W'(N_CHILD - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        terr_d  = 1'b0;
        errc_d  = errc_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_OWN;
                    grant_d = N_CHILD'(1) << pick_idx;
                    busy_d  = 1'b1;
                    owner_d = pick_idx;
                    hcnt_d  = '0;
                end
            end
            S_OWN: begin
                hcnt_d = hcnt_q + 8'd1;
                if (own_done || hold_expired) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next;
                    // A done arriving on the last allowed cycle still counts as success.
                    if (!own_done) begin
                        terr_d = 1'b1;
                        if (errc_q != ERR_MAX) begin
                            errc_d = errc_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            terr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
            terr_q  <= terr_d;
            errc_q  <= errc_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign owner_id    = owner_q;
    assign timeout_err = terr_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_child_slot_scheduler.sv
// Directed and randomized bench for child_slot_scheduler against a
// cycle-level reference built from the scheduling rules.
module tb_child_slot_scheduler;

    localparam int N = 5;
    localparam int T = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         busy;
    logic [2:0]   owner_id;
    logic         timeout_err;
    logic [7:0]   err_count;

    int tests = 0;
    int fails = 0;

    // Reference state
    bit m_own;
    int m_owner;
    int m_ptr;
    int m_h;
    int m_err;
    bit m_terr;

    child_slot_scheduler #(
        .N_CHILD(N),
        .TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .busy       (busy),
        .owner_id   (owner_id),
        .timeout_err(timeout_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        bit found;
        if (!r) begin
            m_own = 0; m_owner = 0; m_ptr = 0; m_h = 0; m_err = 0; m_terr = 0;
            return;
        end
        m_terr = 0;
        if (!m_own) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (!found && rq[c]) begin
                    found = 1;
                    m_own = 1;
                    m_owner = c;
                    m_h = 0;
                end
            end
        end else if (dn[m_owner]) begin
            m_own = 0;
            m_ptr = (m_owner + 1) % N;
        end else if (m_h == T - 1) begin
            m_own = 0;
            m_ptr = (m_owner + 1) % N;
            m_terr = 1;
            if (m_err < 255) m_err++;
        end else begin
            m_h++;
        end
    endtask

    function automatic logic [N-1:0] odone();
        logic [N-1:0] v;
        v = 1;
        return v << m_owner;
    endfunction

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        eg = m_own ? odone() : '0;
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(m_own));
        chk({tag, ".owner"}, 32'(owner_id), 32'(m_owner));
        chk({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
        chk({tag, ".errc"}, 32'(err_count), 32'(m_err));
    endtask

    task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                        input logic [N-1:0] dn);
        @(negedge clk);
        rst_n = r;
        req   = rq;
        done  = dn;
        @(posedge clk);
        model_edge(r, rq, dn);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        logic         r;
        rst_n = 1'b0;
        req   = '0;
        done  = '0;

        // Reset defaults
        repeat (3) step("reset", 1'b0, 5'b11111, '0);
        step("first", 1'b1, 5'b11111, '0);
        chk("first_grant", 32'(grant), 32'h01);

        // Rotation 0,1,2,3,4,0 with a one-cycle idle gap
        for (int k = 0; k < 5; k++) begin
            repeat (3) step("rot_hold", 1'b1, 5'b11111, '0);
            step("rot_done", 1'b1, 5'b11111, odone());
            chk("rot_gap", 32'(grant), 32'h0);
            step("rot_grant", 1'b1, 5'b11111, '0);
            chk("rot_owner", 32'(owner_id), 32'((k + 1) % 5));
        end

        // Wrap and skip
        step("wrap_rst", 1'b0, '0, '0);
        step("wrap_g2", 1'b1, 5'b00100, '0);
        step("wrap_rel", 1'b1, 5'b00011, odone());
        step("wrap_g0", 1'b1, 5'b00011, '0);
        chk("wrap_grant", 32'(grant), 32'h01);
        chk("wrap_owner", 32'(owner_id), 32'h0);

        // Timeout
        step("to_rst", 1'b0, '0, '0);
        step("to_g1", 1'b1, 5'b00010, '0);
        repeat (T - 1) step("to_hold", 1'b1, 5'b00110, '0);
        chk("to_still", 32'(grant), 32'h02);
        step("to_rel", 1'b1, 5'b00110, '0);
        chk("to_drop", 32'(grant), 32'h0);
        chk("to_terr", 32'(timeout_err), 32'h1);
        chk("to_errc", 32'(err_count), 32'h1);
        step("to_next", 1'b1, 5'b00110, '0);
        chk("to_next_grant", 32'(grant), 32'h04);
        chk("to_terr_clr", 32'(timeout_err), 32'h0);

        // Foreign done, then owner done on the last allowed cycle
        step("fd_rst", 1'b0, '0, '0);
        step("fd_g2", 1'b1, 5'b00100, '0);
        step("fd_foreign", 1'b1, '0, 5'b01001);
        chk("fd_hold", 32'(grant), 32'h04);
        for (int i = 0; i < T && m_h < T - 1; i++) step("fd_wait", 1'b1, '0, '0);
        step("fd_sim", 1'b1, '0, odone());
        chk("sim_grant", 32'(grant), 32'h0);
        chk("sim_terr", 32'(timeout_err), 32'h0);
        chk("sim_errc", 32'(err_count), 32'h0);

        // Mid-grant reset
        step("mr_rst", 1'b0, '0, '0);
        step("mr_g4", 1'b1, 5'b10000, '0);
        step("mr_hold", 1'b1, 5'b10000, '0);
        step("mr_reset", 1'b0, 5'b10000, '0);
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_terr", 32'(timeout_err), 32'h0);
        step("mr_after", 1'b1, 5'b11111, '0);
        chk("mr_ptr0", 32'(grant), 32'h01);

        // Error counter saturation
        step("sat_rst", 1'b0, '0, '0);
        repeat (270 * (T + 1)) step("sat", 1'b1, 5'b00001, '0);
        chk("sat_errc", 32'(err_count), 32'hFF);

        // Randomized traffic
        step("rnd_rst", 1'b0, '0, '0);
        repeat (1500) begin
            r  = ($urandom_range(0, 99) != 0);
            rq = N'($urandom);
            if ($urandom_range(0, 3) == 0) dn = odone();
            else if ($urandom_range(0, 6) == 0) dn = N'($urandom);
            else dn = '0;
            step("rnd", r, rq, dn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
